mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Parametrised multicycle MIPS control unit with its own state register, replacing the externally sequenced decoder. It sequences each instruction from opcode through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK-class states. It stalls on a memory ready handshake and traps illegal opcodes and memory timeouts into a sticky fault state. It sits between the instruction register opcode field and the datapath muxes and enables.

## Interface
Parameters:
- WAIT_MAX, 15: max consecutive stall cycles in a memory state before fault; 0 disables timeout.
- WAIT_W, 4: width of the wait counter; must satisfy WAIT_MAX < 2^WAIT_W.
- CNT_W, 32: width of the performance counters.

Ports (clock and reset first):
- clk  in  1  single clock; every flop is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction opcode field (IR[31:26]).
- mem_ready  in  1  memory completes this cycle's access.
- pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a  out  1 each  datapath enables and selects.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 funct-decode, 11 opcode-decode (andi/ori).
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01 illegal opcode, 10 memory timeout.
- instr_retired, cycle_count  out  CNT_W each  performance counters.

## Operation
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, FAULT 15. Codes 12–14 are unused and go to FAULT with code 01.
- FETCH: mem_read, alu_src_b=01, alu_op=00. ir_write and pc_write assert only when mem_ready=1. Advances to DECODE on mem_ready, otherwise holds.
- DECODE: alu_src_b=11. Transitions by opcode:
  - 100011 (lw) and 101011 (sw) → MEM_ADDR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) and 000101 (bne) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi), 001100 (andi), 001101 (ori) → IMM_EXEC.
  - Any other opcode → FAULT, fault_code=01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Goes to MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read, i_or_d. Goes to MEM_WB on mem_ready, otherwise holds.
- MEM_WRITE: mem_write, i_or_d. Goes to FETCH on mem_ready, otherwise holds.
- MEM_WB: reg_write, mem_to_reg, reg_dst=0. Goes to FETCH.
- EXECUTE: alu_src_a=1, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_write, reg_dst=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01, branch_ne=(opcode==000101). Goes to FETCH.
- JUMP: pc_write, pc_source=10. Goes to FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for addi, 11 for andi/ori. Goes to IMM_WB.
- IMM_WB: reg_write, reg_dst=0. Goes to FETCH.
- Wait counter:
  - Clears on every state change and whenever mem_ready=1.
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - When it equals WAIT_MAX (WAIT_MAX≠0) and mem_ready=0, next state is FAULT with fault_code=10.
  - mem_ready=1 in that same cycle wins: the access completes normally.
- FAULT: all enables are 0. Only rst leaves FAULT. fault and fault_code hold their values.

## Timing
- Outputs are combinational from the state register, plus mem_ready gating in FETCH.
- opcode is sampled only in DECODE and later states. The IR holds it stable from DECODE until the next FETCH.
- Cycles per instruction with zero wait: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3. Each wait cycle adds 1.
- While rst=1 and on the first cycle after it deasserts:
  - state=FETCH.
  - Wait counter, fault, fault_code and counters are 0.
  - During rst, all enables are forced to 0.
- rst mid-instruction aborts it. No write enable asserts in the reset cycle.

## Configuration
- MC_PERF_CNT_EN defined:
  - cycle_count increments every cycle with rst=0 and state≠FAULT.
  - instr_retired increments on the final cycle of each instruction: MEM_WB, ALU_WB, IMM_WB, BRANCH, JUMP, and MEM_WRITE with mem_ready.
  - Both counters wrap modulo 2^CNT_W.
- MC_PERF_CNT_EN undefined: both ports are present and tied to 0, and no counter flops exist.

## Structure
- Package mc_ctrl_pkg holds:
  - the state encoding constants (4-bit);
  - the opcode constants;
  - the alu_op, alu_src_b and pc_source encodings;
  - the fault code constants.
- Sub-module mc_wait_timer holds the WAIT_W counter. Inputs: clear, inc. Output: expired = (count==WAIT_MAX && WAIT_MAX!=0).
- The top level holds the next-state logic, output decode and the optional counters.

## Test plan
- rst, then lw (100011) with mem_ready always 1 → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
- R-type, then beq (000100), then bne (000101), mem_ready=1 → CPI 4,3,3; branch_ne=1 only in the bne BRANCH cycle.
- sw with mem_ready low 3 cycles in MEM_WRITE, WAIT_MAX=15 → 3 stall cycles, mem_write held throughout, then FETCH.
- FETCH with mem_ready held 0, WAIT_MAX=4 → FAULT after 5 FETCH cycles, fault_code=10, ir_write never 1; rst recovers to FETCH.
- opcode 111111 in DECODE → FAULT with code 01 next cycle; a later opcode change has no effect.
- MC_PERF_CNT_EN with CNT_W=4: run 20 j instructions → instr_retired=4 (wrapped at 16); cycle_count=12 (60 mod 16).

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared encodings for the multicycle MIPS control unit: state
//            codes, opcodes, datapath select encodings and fault codes.
// Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

  // State encoding; codes 12..14 are deliberately unused.
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_IMM_EXEC  = 4'd10,
    ST_IMM_WB    = 4'd11,
    ST_FAULT     = 4'd15
  } state_e;

  // Opcode field values (IR[31:26]).
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  // ALU operation select.
  localparam logic [1:0] C_ALU_ADD   = 2'b00;
  localparam logic [1:0] C_ALU_SUB   = 2'b01;
  localparam logic [1:0] C_ALU_FUNCT = 2'b10;
  localparam logic [1:0] C_ALU_OPC   = 2'b11;

  // ALU B operand select.
  localparam logic [1:0] C_SRCB_B       = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR    = 2'b01;
  localparam logic [1:0] C_SRCB_IMM     = 2'b10;
  localparam logic [1:0] C_SRCB_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] C_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] C_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] C_PCSRC_JUMP   = 2'b10;

  // Fault codes.
  localparam logic [1:0] C_FAULT_NONE    = 2'b00;
  localparam logic [1:0] C_FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] C_FAULT_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mc_wait_timer
// Brief    : Consecutive-stall counter for memory states. expired_o flags that
//            the stall budget WAIT_MAX is used up (never when WAIT_MAX is 0).
// Revision : 1.0  initial release
// ============================================================================
module mc_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [WAIT_W-1:0] C_MAX = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] count_q;

  // Stall counter: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WAIT_W'(1);
    end
  end

  assign expired_o = (WAIT_MAX != 0) && (count_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multicycle MIPS control unit. Sequences each instruction through
//            fetch/decode/execute/memory/writeback states, stalls on
//            mem_ready, and traps illegal opcodes and memory timeouts into a
//            sticky FAULT state left only by rst.
//            Optional macro MC_PERF_CNT_EN enables the instr_retired and
//            cycle_count counters; otherwise both ports read 0.
// Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_retired,
  output logic [CNT_W-1:0] cycle_count
);

  state_e     state_q, state_d;
  logic [1:0] fault_code_q, fault_code_d;
  logic       w_expired;
  logic       w_stall;

  // Stall states wait on mem_ready; the counter restarts on any progress.
  assign w_stall = ((state_q == ST_FETCH) || (state_q == ST_MEM_READ) ||
                    (state_q == ST_MEM_WRITE)) && !mem_ready;

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   ((state_d != state_q) || mem_ready),
    .inc_i     (w_stall),
    .expired_o (w_expired)
  );

  // State and fault-code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      fault_code_q <= C_FAULT_NONE;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Next-state and datapath control decode; everything is forced low in reset.
  always_comb begin
    state_d       = state_q;
    fault_code_d  = fault_code_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = C_SRCB_B;
    alu_op        = C_ALU_ADD;
    pc_source     = C_PCSRC_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = C_SRCB_FOUR;
        alu_op    = C_ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (w_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = C_FAULT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        alu_src_b = C_SRCB_IMM_SH2;
        case (opcode)
          C_OP_LW, C_OP_SW:               state_d = ST_MEM_ADDR;
          C_OP_RTYPE:                     state_d = ST_EXECUTE;
          C_OP_BEQ, C_OP_BNE:             state_d = ST_BRANCH;
          C_OP_J:                         state_d = ST_JUMP;
          C_OP_ADDI, C_OP_ANDI, C_OP_ORI: state_d = ST_IMM_EXEC;
          default: begin
            state_d      = ST_FAULT;
            fault_code_d = C_FAULT_ILLEGAL;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = C_SRCB_IMM;
        state_d   = (opcode == C_OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (w_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = C_FAULT_TIMEOUT;
        end
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = ST_FETCH;
        end else if (w_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = C_FAULT_TIMEOUT;
        end
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
        state_d    = ST_FETCH;
      end
      ST_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = C_ALU_FUNCT;
        state_d   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = C_ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = C_PCSRC_ALUOUT;
        branch_ne     = (opcode == C_OP_BNE);
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = C_PCSRC_JUMP;
        state_d   = ST_FETCH;
      end
      ST_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = C_SRCB_IMM;
        alu_op    = (opcode == C_OP_ADDI) ? C_ALU_ADD : C_ALU_OPC;
        state_d   = ST_IMM_WB;
      end
      ST_IMM_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b0;
        state_d   = ST_FETCH;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d      = ST_FAULT;
        fault_code_d = C_FAULT_ILLEGAL;
      end
    endcase

    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = C_SRCB_B;
      alu_op        = C_ALU_ADD;
      pc_source     = C_PCSRC_ALU;
    end
  end

  assign state      = rst ? ST_FETCH : state_q;
  assign fault      = !rst && (state_q == ST_FAULT);
  assign fault_code = rst ? C_FAULT_NONE : fault_code_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] instr_retired_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic             w_retire;

  // An instruction retires on its last cycle; a store only once memory accepts it.
  assign w_retire = (state_q == ST_MEM_WB)  || (state_q == ST_ALU_WB) ||
                    (state_q == ST_IMM_WB)  || (state_q == ST_BRANCH) ||
                    (state_q == ST_JUMP)    ||
                    ((state_q == ST_MEM_WRITE) && mem_ready);

  // Free-running performance counters, frozen while faulted, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_retired_q <= '0;
      cycle_count_q   <= '0;
    end else begin
      if (state_q != ST_FAULT) begin
        cycle_count_q <= cycle_count_q + CNT_W'(1);
      end
      if (w_retire) begin
        instr_retired_q <= instr_retired_q + CNT_W'(1);
      end
    end
  end

  assign instr_retired = instr_retired_q;
  assign cycle_count   = cycle_count_q;
`else
  assign instr_retired = '0;
  assign cycle_count   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Directed self-checking bench for mc_control_fsm (WAIT_MAX=4,
//            CNT_W=4). Counter expectations follow MC_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, branch_ne, i_or_d, mem_read;
  logic             mem_write, mem_to_reg, ir_write, reg_write, reg_dst;
  logic             alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [3:0]       state;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] instr_retired, cycle_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(
    .WAIT_MAX (4),
    .WAIT_W   (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .state         (state),
    .fault         (fault),
    .fault_code    (fault_code),
    .instr_retired (instr_retired),
    .cycle_count   (cycle_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH back to FETCH with mem_ready=1.
  task automatic run_instr(input string tag, input logic [5:0] op, input int exp_cpi,
                           input logic exp_bne);
    int   n;
    logic bne_obs;
    logic bne_stray;
    n         = 0;
    bne_obs   = 1'b0;
    bne_stray = 1'b0;
    opcode    = op;
    mem_ready = 1'b1;
    do begin
      if (state == 4'd8) bne_obs = branch_ne;
      else if (branch_ne) bne_stray = 1'b1;
      step();
      n++;
    end while (state != 4'd0 && n < 16);
    check_eq({tag, "_cpi"}, 32'(n), 32'(exp_cpi));
    check_eq({tag, "_bne"}, 32'(bne_obs), 32'(exp_bne));
    check_eq({tag, "_bne_stray"}, 32'(bne_stray), 0);
  endtask

  initial begin
    int lw_states [6];
    lw_states = '{0, 1, 2, 3, 4, 0};

    rst       = 1'b1;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    step();
    step();
    // In reset: everything quiet even with mem_ready=1 in FETCH.
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_mem_read", 32'(mem_read), 0);
    check_eq("rst_ir_write", 32'(ir_write), 0);
    check_eq("rst_pc_write", 32'(pc_write), 0);
    check_eq("rst_fault", 32'(fault), 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_state", 32'(state), 0);
    check_eq("post_rst_code", 32'(fault_code), 0);
    check_eq("post_rst_instr", 32'(instr_retired), 0);
    check_eq("post_rst_cycles", 32'(cycle_count), 0);
    check_eq("fetch_ir_write", 32'(ir_write), 1);
    check_eq("fetch_srcb", 32'(alu_src_b), 1);

    // lw with zero wait.
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("lw_state%0d", i), 32'(state), 32'(lw_states[i]));
      check_eq($sformatf("lw_regw%0d", i), 32'(reg_write), 32'(i == 4));
      check_eq($sformatf("lw_m2r%0d", i), 32'(mem_to_reg), 32'(i == 4));
      if (i < 5) step();
    end

    run_instr("rtype", 6'b000000, 4, 1'b0);
    run_instr("beq", 6'b000100, 3, 1'b0);
    run_instr("bne", 6'b000101, 3, 1'b1);
    run_instr("addi", 6'b001000, 4, 1'b0);

    // sw with 3 stall cycles in MEM_WRITE.
    opcode    = 6'b101011;
    mem_ready = 1'b1;
    step();
    step();
    check_eq("sw_addr_srcb", 32'(alu_src_b), 2);
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("sw_stall_state%0d", i), 32'(state), 5);
      check_eq($sformatf("sw_stall_mw%0d", i), 32'(mem_write), 1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("sw_done_state", 32'(state), 5);
    check_eq("sw_done_mw", 32'(mem_write), 1);
    step();
    check_eq("sw_back_fetch", 32'(state), 0);

    // FETCH timeout with WAIT_MAX=4.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("to_fetch%0d", i), 32'(state), 0);
      check_eq($sformatf("to_irw%0d", i), 32'(ir_write), 0);
      step();
    end
    check_eq("to_state", 32'(state), 15);
    check_eq("to_fault", 32'(fault), 1);
    check_eq("to_code", 32'(fault_code), 2);
    check_eq("to_mem_read", 32'(mem_read), 0);
    mem_ready = 1'b1;
    step();
    check_eq("to_sticky", 32'(state), 15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("to_recover_state", 32'(state), 0);
    check_eq("to_recover_fault", 32'(fault), 0);
    check_eq("to_recover_code", 32'(fault_code), 0);

    // Illegal opcode.
    opcode    = 6'b111111;
    mem_ready = 1'b1;
    step();
    check_eq("ill_decode", 32'(state), 1);
    step();
    check_eq("ill_state", 32'(state), 15);
    check_eq("ill_code", 32'(fault_code), 1);
    opcode = 6'b100011;
    step();
    check_eq("ill_hold_state", 32'(state), 15);
    check_eq("ill_hold_code", 32'(fault_code), 1);
    check_eq("ill_hold_mem_read", 32'(mem_read), 0);

    // Performance counters over 20 jumps.
    rst = 1'b1;
    step();
    rst    = 1'b0;
    opcode = 6'b000010;
    #1;
    for (int i = 0; i < 60; i++) begin
      if (i == 2) begin
        check_eq("j_pc_write", 32'(pc_write), 1);
        check_eq("j_pc_source", 32'(pc_source), 2);
      end
      step();
    end
    check_eq("perf_state", 32'(state), 0);
`ifdef MC_PERF_CNT_EN
    check_eq("perf_instr", 32'(instr_retired), 4);
    check_eq("perf_cycles", 32'(cycle_count), 12);
`else
    check_eq("perf_instr", 32'(instr_retired), 0);
    check_eq("perf_cycles", 32'(cycle_count), 0);
`endif

    // Reset mid-instruction: lw reaches MEM_WB, then rst asserts.
    opcode = 6'b100011;
    for (int i = 0; i < 4; i++) step();
    check_eq("abort_pre_state", 32'(state), 4);
    check_eq("abort_pre_regw", 32'(reg_write), 1);
    rst = 1'b1;
    #1;
    check_eq("abort_regw", 32'(reg_write), 0);
    check_eq("abort_state", 32'(state), 0);
    step();
    rst = 1'b0;
    #1;
    check_eq("abort_after_state", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
